// File: rtl/item_memory_sram_arbiter_pkg.sv
// Shared constants, in-flight entry type and helpers for the item-memory SRAM read arbiter.
package item_memory_sram_arbiter_pkg;

    localparam int unsigned NUM_MODALITIES  = 3;
    localparam int unsigned IM_SRAM_LATENCY = 1;
    localparam int unsigned HV_DIMENSION    = 2000;
    localparam int unsigned INPUT_CHANNELS  = 256;
    localparam int unsigned ID_WIDTH        = 2;

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } inflight_t;

    function automatic int unsigned ceil_log2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [ID_WIDTH-1:0] onehot_to_id(input logic [NUM_MODALITIES-1:0] oh);
        logic [ID_WIDTH-1:0] id;
        id = '0;
        for (int unsigned i = 0; i < NUM_MODALITIES; i++) begin
            if (oh[i]) id = ID_WIDTH'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/item_memory_sram_arbiter_if.sv
// Requester-side handshakes and SRAM read port of the item-memory arbiter.
interface item_memory_sram_arbiter_if
    import item_memory_sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ceil_log2(INPUT_CHANNELS),
    parameter int unsigned DATA_WIDTH = HV_DIMENSION
);
    logic [NUM_MODALITIES-1:0]            ReqValid_SI;
    logic [NUM_MODALITIES*ADDR_WIDTH-1:0] ReqAddr_DI;
    logic [NUM_MODALITIES-1:0]            ReqReady_SO;
    logic [NUM_MODALITIES-1:0]            RspValid_SO;
    logic [NUM_MODALITIES-1:0]            RspReady_SI;
    logic [NUM_MODALITIES*DATA_WIDTH-1:0] RspData_DO;
    logic                                 SramEn_SO;
    logic [ADDR_WIDTH-1:0]                SramAddr_DO;
    logic [DATA_WIDTH-1:0]                SramRdata_DI;

    modport slave (
        input  ReqValid_SI, ReqAddr_DI, RspReady_SI, SramRdata_DI,
        output ReqReady_SO, RspValid_SO, RspData_DO, SramEn_SO, SramAddr_DO
    );

    modport master (
        output ReqValid_SI, ReqAddr_DI, RspReady_SI, SramRdata_DI,
        input  ReqReady_SO, RspValid_SO, RspData_DO, SramEn_SO, SramAddr_DO
    );
endinterface

// File: rtl/item_memory_sram_arbiter_rr_arbiter3.sv
// Three-way grant selection: round-robin from (ptr+1), or fixed 0>1>2 when
// ARB_FIXED_PRIORITY_EN is defined.
module rr_arbiter3
    import item_memory_sram_arbiter_pkg::*;
(
    input  logic [NUM_MODALITIES-1:0] eligible,
    input  logic [ID_WIDTH-1:0]       ptr,
    output logic [NUM_MODALITIES-1:0] grant,
    output logic [ID_WIDTH-1:0]       ptr_next
);

`ifdef ARB_FIXED_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant    = '0;
        ptr_next = '0;
        for (int i = int'(NUM_MODALITIES) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
                ptr_next = ID_WIDTH'(i);
            end
        end
    end
`else
    logic                found;
    logic [ID_WIDTH-1:0] idx;

    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_MODALITIES; k++) begin
            idx = ID_WIDTH'((32'(ptr) + 32'd1 + k) % NUM_MODALITIES);
            for (int unsigned i = 0; i < NUM_MODALITIES; i++) begin
                if (!found && idx == ID_WIDTH'(i) && eligible[i]) begin
                    grant[i] = 1'b1;
                    ptr_next = idx;
                    found    = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/item_memory_sram_arbiter.sv
// Shares one item-memory SRAM read port among three modality requesters.
// Build option: ARB_FIXED_PRIORITY_EN selects fixed priority and drops the pointer.
module item_memory_sram_arbiter
    import item_memory_sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ceil_log2(INPUT_CHANNELS),
    parameter int unsigned DATA_WIDTH   = HV_DIMENSION,
    parameter int unsigned SRAM_LATENCY = IM_SRAM_LATENCY
)(
    input  logic                        Clk_CI,
    input  logic                        Reset_RBI,
    input  logic                        Clear_SI,
    item_memory_sram_arbiter_if.slave   bus,
    output logic                        Busy_SO
);

    logic [NUM_MODALITIES-1:0]                 eligible;
    logic [NUM_MODALITIES-1:0]                 grant;
    logic [NUM_MODALITIES-1:0]                 inflight_mask;
    logic [NUM_MODALITIES-1:0]                 rsp_valid;
    logic [NUM_MODALITIES-1:0][DATA_WIDTH-1:0] rsp_data;
    logic [ID_WIDTH-1:0]                       ptr;
    logic [ID_WIDTH-1:0]                       ptr_next;
    logic [ADDR_WIDTH-1:0]                     sram_addr;
    inflight_t [SRAM_LATENCY-1:0]              pipe;
    inflight_t                                 tail;

    // A requester with a read anywhere in the pipeline is not eligible again.
    always_comb begin
        inflight_mask = '0;
        for (int unsigned i = 0; i < NUM_MODALITIES; i++) begin
            for (int unsigned s = 0; s < SRAM_LATENCY; s++) begin
                if (pipe[s].valid && pipe[s].id == ID_WIDTH'(i)) inflight_mask[i] = 1'b1;
            end
        end
    end

    assign eligible = bus.ReqValid_SI & ~inflight_mask & ~rsp_valid
                    & {NUM_MODALITIES{Reset_RBI & ~Clear_SI}};

    rr_arbiter3 u_arb (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

`ifdef ARB_FIXED_PRIORITY_EN
    logic unused_ptr_next;
    assign ptr             = ID_WIDTH'(NUM_MODALITIES - 1);
    assign unused_ptr_next = ^ptr_next;
`else
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI)  ptr <= ID_WIDTH'(NUM_MODALITIES - 1);
        else if (|grant) ptr <= ptr_next;
    end
`endif

    always_comb begin
        sram_addr = '0;
        for (int unsigned i = 0; i < NUM_MODALITIES; i++) begin
            if (grant[i]) sram_addr = bus.ReqAddr_DI[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    assign bus.ReqReady_SO = grant;
    assign bus.SramEn_SO   = |grant;
    assign bus.SramAddr_DO = sram_addr;

    // Requester id travels alongside the read for SRAM_LATENCY edges.
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI || Clear_SI) begin
            pipe <= '0;
        end else begin
            pipe[0] <= '{valid: |grant, id: onehot_to_id(grant)};
            for (int unsigned s = 1; s < SRAM_LATENCY; s++) pipe[s] <= pipe[s-1];
        end
    end

    assign tail = pipe[SRAM_LATENCY-1];

    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_MODALITIES; i++) begin
                if (Clear_SI) begin
                    rsp_valid[i] <= 1'b0;
                end else if (tail.valid && tail.id == ID_WIDTH'(i)) begin
                    rsp_valid[i] <= 1'b1;
                    rsp_data[i]  <= bus.SramRdata_DI;
                end else if (rsp_valid[i] && bus.RspReady_SI[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.RspValid_SO = rsp_valid;
    assign bus.RspData_DO  = rsp_data;
    assign Busy_SO         = (|rsp_valid) | (|inflight_mask);

endmodule
